reset_rx_detector: RTL and testbench
====================================

// Module: reset_rx_detector
// PURPOSE
// - Receive-side counterpart of the Hard/Cable Reset transmit path in the TCPC.
// - Watches decoded 5b K-code symbols from the PHY and detects Hard Reset and Cable Reset ordered sets.
// - Gates each detection by its RECEIVE_DETECT enable bit.
// - Reports detections through sticky ALERT bits and the frame-type field; on a Hard Reset, requests the register file to clear RECEIVE_DETECT.
// PARAMETERS
// - GAP_TIMEOUT  16  idle cycles without symbol_valid before the line counts as idle (window flush, lockout exit)
// - MATCH_MIN    3   minimum matching symbol positions (of 4) to accept an ordered set
// PORTS
// - CLK                   in   1   system clock, rising edge
// - reset                 in   1   asynchronous, active-high reset
// - symbol_valid          in   1   one-cycle strobe: symbol carries a new K-code
// - symbol                in   5   5b K-code from PHY decoder
// - RECEIVE_DETECT        in   8   bit5 = enable Hard Reset rx, bit6 = enable Cable Reset rx
// - ALERT_clear           in   16  write-1-to-clear mask from the register interface
// - ALERT                 out  16  sticky alert bits: bit3 = Received Hard Reset, bit2 = Received SOP Message Status
// - rx_frame_type         out  3   3'b101 = Hard Reset, 3'b110 = Cable Reset, 3'b000 = none
// - hard_reset_rx         out  1   one-cycle pulse on an accepted Hard Reset
// - cable_reset_rx        out  1   one-cycle pulse on an accepted Cable Reset
// - receive_detect_clear  out  1   one-cycle pulse: register file zeroes RECEIVE_DETECT
// BEHAVIOUR
// - Reset: all outputs 0, state = HUNT, window and counters cleared.
// - K-codes:
//   - RST1 = 5'b00111, RST2 = 5'b11001, SYNC1 = 5'b11000, SYNC3 = 5'b00110
//   - Hard Reset = RST1,RST1,RST1,RST2; Cable Reset = RST1,SYNC1,RST1,SYNC3 (first received first)
// - Window: 4-entry shift register, loaded only on symbol_valid; fill counter 0..4, saturates at 4.
// - Gap counter: increments on every cycle without symbol_valid and clears on symbol_valid; saturates at GAP_TIMEOUT.
// - States:
//   - HUNT: on symbol_valid, shift the window. Once fill == 4, evaluate every new symbol (sliding).
//   - Match: count of equal positions >= MATCH_MIN.
//   - HR match with RECEIVE_DETECT[5]=1 -> report HR, go to LOCKOUT.
//   - Else CR match with RECEIVE_DETECT[6]=1 -> report CR, go to LOCKOUT.
//   - A match whose enable bit is 0 is ignored; stay in HUNT.
//   - Gap reaching GAP_TIMEOUT in HUNT clears fill to 0.
//   - LOCKOUT: symbols are ignored (no evaluation). Exit to HUNT with fill = 0 when gap reaches GAP_TIMEOUT.
//   - This gives one report per ordered set even with trailing symbols.
// - Priority: a window matching both patterns (e.g. RST1,RST1,RST1,SYNC3) is reported as Hard Reset.
// - Latency: completing symbol sampled at edge N; ALERT, pulses and rx_frame_type are visible after edge N+1.
// - Report HR:
//   - set ALERT[3], rx_frame_type = 3'b101
//   - pulse hard_reset_rx and receive_detect_clear
// - Report CR:
//   - set ALERT[2], rx_frame_type = 3'b110
//   - pulse cable_reset_rx; RECEIVE_DETECT is not cleared
// - ALERT: per bit, next = (ALERT & ~ALERT_clear) | set. A set wins over a clear in the same cycle.
//   - Bits other than 2 and 3 stay 0.
// - rx_frame_type holds until the next report or until ALERT_clear clears the corresponding ALERT bit, then returns to 0.
// - RECEIVE_DETECT changes mid-window take effect at the next evaluation; no retroactive reports.
// - Reset asserted mid-window or in LOCKOUT aborts immediately: state HUNT, fill 0, no pulse emitted.
// STRUCTURE
// - Shared package reset_pkg:
//   - K-code constants, HR/CR pattern arrays
//   - RECEIVE_DETECT and ALERT bit indices, frame-type codes, state enum {HUNT, LOCKOUT}
// - Sub-module kcode_match: combinational; inputs window[4][5] and pattern[4][5], output 3-bit match count.
//   - Instantiated twice (HR, CR); the comparator against MATCH_MIN stays in the top module.
// - Top module holds the window, counters, FSM, ALERT register and pulse registers.
// TESTING
// - HR exact: RECEIVE_DETECT=8'h20, symbols 07,07,07,19 back-to-back
//   -> ALERT=16'h0008, rx_frame_type=5, one hard_reset_rx and one receive_detect_clear pulse.
// - CR with one corrupted symbol: RECEIVE_DETECT=8'h40, symbols 07,18,1F,06 (3/4 match)
//   -> ALERT=16'h0004, rx_frame_type=6, cable_reset_rx pulse, no receive_detect_clear.
// - Disabled: RECEIVE_DETECT=8'h00, HR sequence -> ALERT stays 0, no pulses.
//   - Same stimulus with bit5 set after the line goes idle -> reported.
// - Lockout and idle:
//   - HR then 07,07,07,19 repeated with no gap -> exactly one report.
//   - Repeat after >= 16 idle cycles -> second report.
// - Set/clear collision: ALERT_clear=16'h0008 on the same cycle the HR set occurs -> ALERT[3]=1.
//   - A later clear -> ALERT[3]=0, rx_frame_type=0.
// - Async reset after the 3rd symbol of HR -> outputs 0 within the reset cycle.
//   - A subsequent 19 alone produces no report.

Source files
------------

// File: rtl/reset_rx_detector_pkg.sv
// Shared types and constants for the Hard/Cable Reset receive detector.
// K-codes, ordered-set patterns, register bit positions and FSM states.
package reset_pkg;

  localparam int GAP_TIMEOUT = 16;
  localparam int MATCH_MIN   = 3;
  localparam int GAP_W       = $clog2(GAP_TIMEOUT + 1);

  typedef logic [4:0] kcode_t;
  // Index 0 holds the oldest symbol of the window.
  typedef logic [3:0][4:0] win_t;

  localparam kcode_t K_RST1  = 5'b00111;
  localparam kcode_t K_RST2  = 5'b11001;
  localparam kcode_t K_SYNC1 = 5'b11000;
  localparam kcode_t K_SYNC3 = 5'b00110;

  localparam win_t HR_PAT = {K_RST2, K_RST1, K_RST1, K_RST1};
  localparam win_t CR_PAT = {K_SYNC3, K_RST1, K_SYNC1, K_RST1};

  localparam int RD_HR_BIT = 5;
  localparam int RD_CR_BIT = 6;
  localparam int AL_HR_BIT = 3;
  localparam int AL_CR_BIT = 2;

  localparam logic [15:0] ALERT_MASK = 16'h000C;

  localparam logic [2:0] FT_NONE = 3'b000;
  localparam logic [2:0] FT_HR   = 3'b101;
  localparam logic [2:0] FT_CR   = 3'b110;

  typedef enum logic {
    HUNT,
    LOCKOUT
  } state_e;

endpackage

// File: rtl/reset_rx_detector_if.sv
// Symbol, register and report signals between PHY/register file
// and the reset receive detector.
interface reset_rx_detector_if;

  logic        symbol_valid;
  logic [4:0]  symbol;
  logic [7:0]  RECEIVE_DETECT;
  logic [15:0] ALERT_clear;
  logic [15:0] ALERT;
  logic [2:0]  rx_frame_type;
  logic        hard_reset_rx;
  logic        cable_reset_rx;
  logic        receive_detect_clear;

  modport master (
    output symbol_valid,
    output symbol,
    output RECEIVE_DETECT,
    output ALERT_clear,
    input  ALERT,
    input  rx_frame_type,
    input  hard_reset_rx,
    input  cable_reset_rx,
    input  receive_detect_clear
  );

  modport slave (
    input  symbol_valid,
    input  symbol,
    input  RECEIVE_DETECT,
    input  ALERT_clear,
    output ALERT,
    output rx_frame_type,
    output hard_reset_rx,
    output cable_reset_rx,
    output receive_detect_clear
  );

endinterface

// File: rtl/reset_rx_detector_kcode_match.sv
// Counts how many of the four window positions equal the pattern.
// Purely combinational; thresholding is done by the caller.
module kcode_match
  import reset_pkg::*;
(
  input  win_t       win_i,
  input  win_t       pat_i,
  output logic [2:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (win_i[i] == pat_i[i]) begin
        cnt_o = cnt_o + 3'd1;
      end
    end
  end

endmodule

// File: rtl/reset_rx_detector.sv
// Detects Hard/Cable Reset ordered sets in the received K-code stream
// and reports them through sticky ALERT bits and one-cycle pulses.
module reset_rx_detector
  import reset_pkg::*;
(
  input  logic CLK,
  input  logic reset,
  reset_rx_detector_if.slave bus
);

  state_e           state_q, state_d;
  win_t             win_q, win_d;
  logic [2:0]       fill_q, fill_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             eval_q, eval_d;
  logic [15:0]      alert_q, alert_d, alert_set;
  logic [2:0]       ft_q, ft_d;
  logic             hr_q, hr_d;
  logic             cr_q, cr_d;
  logic             rdc_q, rdc_d;

  logic [2:0] hr_cnt, cr_cnt;
  logic       hr_hit, cr_hit, idle;
  logic       unused_rd;

  kcode_match u_hr_match (
    .win_i (win_q),
    .pat_i (HR_PAT),
    .cnt_o (hr_cnt)
  );

  kcode_match u_cr_match (
    .win_i (win_q),
    .pat_i (CR_PAT),
    .cnt_o (cr_cnt)
  );

  assign hr_hit = hr_cnt >= 3'(MATCH_MIN);
  assign cr_hit = cr_cnt >= 3'(MATCH_MIN);
  assign idle   = gap_q == GAP_W'(GAP_TIMEOUT);

  assign unused_rd = ^{bus.RECEIVE_DETECT[7],
                       bus.RECEIVE_DETECT[4:0]};

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    fill_d    = fill_q;
    gap_d     = gap_q;
    eval_d    = 1'b0;
    alert_set = '0;
    ft_d      = ft_q;
    hr_d      = 1'b0;
    cr_d      = 1'b0;
    rdc_d     = 1'b0;

    if (idle) begin
      fill_d  = '0;
      state_d = HUNT;
    end

    // Frame type follows its ALERT bit when software clears it.
    if ((ft_q == FT_HR && bus.ALERT_clear[AL_HR_BIT]) ||
        (ft_q == FT_CR && bus.ALERT_clear[AL_CR_BIT])) begin
      ft_d = FT_NONE;
    end

    // Window was loaded last edge; judge it against today's enables.
    if (state_q == HUNT && eval_q) begin
      unique case (1'b1)
        hr_hit && bus.RECEIVE_DETECT[RD_HR_BIT]: begin
          state_d              = LOCKOUT;
          alert_set[AL_HR_BIT] = 1'b1;
          ft_d                 = FT_HR;
          hr_d                 = 1'b1;
          rdc_d                = 1'b1;
        end
        cr_hit && bus.RECEIVE_DETECT[RD_CR_BIT]: begin
          state_d              = LOCKOUT;
          alert_set[AL_CR_BIT] = 1'b1;
          ft_d                 = FT_CR;
          cr_d                 = 1'b1;
        end
        default: ;
      endcase
    end

    if (bus.symbol_valid) begin
      win_d = {bus.symbol, win_q[3:1]};
      if (fill_d != 3'd4) begin
        fill_d = fill_d + 3'd1;
      end
      gap_d  = '0;
      eval_d = (state_q == HUNT) && (fill_d == 3'd4);
    end else if (!idle) begin
      gap_d = gap_q + GAP_W'(1);
    end

    alert_d = ((alert_q & ~bus.ALERT_clear) | alert_set)
              & ALERT_MASK;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      win_q   <= '0;
      fill_q  <= '0;
      gap_q   <= '0;
      eval_q  <= 1'b0;
      alert_q <= '0;
      ft_q    <= FT_NONE;
      hr_q    <= 1'b0;
      cr_q    <= 1'b0;
      rdc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      gap_q   <= gap_d;
      eval_q  <= eval_d;
      alert_q <= alert_d;
      ft_q    <= ft_d;
      hr_q    <= hr_d;
      cr_q    <= cr_d;
      rdc_q   <= rdc_d;
    end
  end

  assign bus.ALERT                = alert_q;
  assign bus.rx_frame_type        = ft_q;
  assign bus.hard_reset_rx        = hr_q;
  assign bus.cable_reset_rx       = cr_q;
  assign bus.receive_detect_clear = rdc_q;

endmodule

// File: tb/tb_reset_rx_detector.sv
// Bench for reset_rx_detector: directed scenarios plus random symbol
// streams checked every cycle against a queue-based reference model.
module tb_reset_rx_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reset_rx_detector_if bus ();

  reset_rx_detector dut (
    .CLK   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_miss = 0;
  int n_hr   = 0;
  int n_cr   = 0;
  int n_rdc  = 0;

  bit [4:0] HRP[4] = '{5'h07, 5'h07, 5'h07, 5'h19};
  bit [4:0] CRP[4] = '{5'h07, 5'h18, 5'h07, 5'h06};
  bit [4:0] SYMS[5] = '{5'h07, 5'h19, 5'h18, 5'h06, 5'h1F};
  bit [7:0] RDS[4] = '{8'h00, 8'h20, 8'h40, 8'h60};

  // Reference model: last four received symbols, idle length,
  // lockout flag and a window waiting to be judged next cycle.
  bit [4:0]    m_win[$];
  bit [4:0]    m_pwin[$];
  int          m_gap;
  bit          m_lock;
  bit          m_pend;
  logic [15:0] e_alert;
  logic [2:0]  e_ft;
  logic        e_hr, e_cr, e_rdc;

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int score(input bit [4:0] w[$],
                               input bit [4:0] p[4]);
    int s = 0;
    for (int i = 0; i < 4; i++) if (w[i] == p[i]) s++;
    return s;
  endfunction

  task automatic model_reset();
    m_win.delete();
    m_pwin.delete();
    m_gap   = 0;
    m_lock  = 0;
    m_pend  = 0;
    e_alert = '0;
    e_ft    = '0;
    e_hr    = 0;
    e_cr    = 0;
    e_rdc   = 0;
  endtask

  task automatic model(input bit v, input bit [4:0] s,
                       input bit [7:0] rd, input bit [15:0] clr);
    bit          was_lock = m_lock;
    int          was_gap  = m_gap;
    logic [15:0] set      = '0;
    e_hr  = 0;
    e_cr  = 0;
    e_rdc = 0;
    if (was_gap >= 16) begin
      m_lock = 0;
      m_win.delete();
    end
    if ((e_ft == 3'd5 && clr[3]) || (e_ft == 3'd6 && clr[2]))
      e_ft = 0;
    if (m_pend && !was_lock) begin
      if (score(m_pwin, HRP) >= 3 && rd[5]) begin
        set[3] = 1; e_ft = 3'd5; e_hr = 1; e_rdc = 1; m_lock = 1;
      end else if (score(m_pwin, CRP) >= 3 && rd[6]) begin
        set[2] = 1; e_ft = 3'd6; e_cr = 1; m_lock = 1;
      end
    end
    e_alert = (e_alert & ~clr) | set;
    m_pend  = 0;
    if (v) begin
      m_win.push_back(s);
      if (m_win.size() > 4) void'(m_win.pop_front());
      m_gap = 0;
      if (!was_lock && m_win.size() == 4) begin
        m_pend = 1;
        m_pwin = m_win;
      end
    end else if (m_gap < 16) begin
      m_gap++;
    end
  endtask

  task automatic compare_all();
    check("alert", bus.ALERT, e_alert);
    check("ftype", 16'(bus.rx_frame_type), 16'(e_ft));
    check("hr_p", 16'(bus.hard_reset_rx), 16'(e_hr));
    check("cr_p", 16'(bus.cable_reset_rx), 16'(e_cr));
    check("rdc_p", 16'(bus.receive_detect_clear), 16'(e_rdc));
  endtask

  task automatic step(input bit v, input bit [4:0] s,
                      input bit [7:0] rd, input bit [15:0] clr);
    bus.symbol_valid   = v;
    bus.symbol         = s;
    bus.RECEIVE_DETECT = rd;
    bus.ALERT_clear    = clr;
    @(posedge clk);
    model(v, s, rd, clr);
    #1;
    compare_all();
    if (bus.hard_reset_rx) n_hr++;
    if (bus.cable_reset_rx) n_cr++;
    if (bus.receive_detect_clear) n_rdc++;
    @(negedge clk);
  endtask

  task automatic idle_n(input int n, input bit [7:0] rd);
    repeat (n) step(0, 5'h00, rd, 16'h0000);
  endtask

  task automatic send4(input bit [4:0] a, input bit [4:0] b,
                       input bit [4:0] c, input bit [4:0] d,
                       input bit [7:0] rd);
    step(1, a, rd, 16'h0000);
    step(1, b, rd, 16'h0000);
    step(1, c, rd, 16'h0000);
    step(1, d, rd, 16'h0000);
  endtask

  function automatic logic [15:0] rclr();
    return ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0000;
  endfunction

  initial begin
    bus.symbol_valid   = 0;
    bus.symbol         = '0;
    bus.RECEIVE_DETECT = '0;
    bus.ALERT_clear    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 0;

    // Exact Hard Reset.
    send4(5'h07, 5'h07, 5'h07, 5'h19, 8'h20);
    idle_n(3, 8'h20);
    check("hr_alert", bus.ALERT, 16'h0008);
    check("hr_ftype", 16'(bus.rx_frame_type), 16'd5);
    check("hr_count", 16'(n_hr), 16'd1);
    check("hr_rdc", 16'(n_rdc), 16'd1);
    idle_n(18, 8'h20);

    // Async reset after third symbol, then a lone RST2.
    send4(5'h18, 5'h07, 5'h07, 5'h07, 8'h20);
    #2 rst = 1;
    #1;
    check("rst_alert", bus.ALERT, 16'h0000);
    check("rst_ftype", 16'(bus.rx_frame_type), 16'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    step(1, 5'h19, 8'h20, 16'h0000);
    idle_n(4, 8'h20);
    check("rst_nohr", 16'(n_hr), 16'd1);
    idle_n(18, 8'h20);

    // Cable Reset with one corrupted symbol.
    send4(5'h07, 5'h18, 5'h1F, 5'h06, 8'h40);
    idle_n(3, 8'h40);
    check("cr_alert", bus.ALERT, 16'h0004);
    check("cr_ftype", 16'(bus.rx_frame_type), 16'd6);
    check("cr_count", 16'(n_cr), 16'd1);
    check("cr_rdc", 16'(n_rdc), 16'd1);
    step(0, 5'h00, 8'h40, 16'hFFFF);
    idle_n(18, 8'h00);

    // Disabled, then enabled after idle.
    send4(5'h07, 5'h07, 5'h07, 5'h19, 8'h00);
    idle_n(18, 8'h00);
    check("dis_alert", bus.ALERT, 16'h0000);
    check("dis_count", 16'(n_hr), 16'd1);
    send4(5'h07, 5'h07, 5'h07, 5'h19, 8'h20);
    idle_n(2, 8'h20);
    check("en_count", 16'(n_hr), 16'd2);
    idle_n(18, 8'h20);

    // Lockout: back-to-back repeat gives one report.
    send4(5'h07, 5'h07, 5'h07, 5'h19, 8'h20);
    send4(5'h07, 5'h07, 5'h07, 5'h19, 8'h20);
    idle_n(3, 8'h20);
    check("lock_count", 16'(n_hr), 16'd3);
    idle_n(18, 8'h20);
    send4(5'h07, 5'h07, 5'h07, 5'h19, 8'h20);
    idle_n(2, 8'h20);
    check("relock_count", 16'(n_hr), 16'd4);
    idle_n(18, 8'h20);

    // Set/clear collision on ALERT[3].
    step(0, 5'h00, 8'h20, 16'hFFFF);
    send4(5'h07, 5'h07, 5'h07, 5'h19, 8'h20);
    step(0, 5'h00, 8'h20, 16'h0008);
    check("coll_alert", bus.ALERT, 16'h0008);
    idle_n(2, 8'h20);
    step(0, 5'h00, 8'h20, 16'h0008);
    check("clr_alert", bus.ALERT, 16'h0000);
    check("clr_ftype", 16'(bus.rx_frame_type), 16'd0);
    idle_n(18, 8'h20);

    // Random streams of ordered sets, fragments and gaps.
    for (int it = 0; it < 200; it++) begin
      int       kind;
      bit [7:0] rd;
      bit [4:0] seq[4];
      kind = $urandom_range(0, 3);
      rd   = RDS[$urandom_range(0, 3)];
      if (kind == 0) seq = HRP;
      else if (kind == 1) seq = CRP;
      else begin
        for (int k = 0; k < 4; k++)
          seq[k] = SYMS[$urandom_range(0, 4)];
      end
      if (kind < 2 && $urandom_range(0, 2) == 0)
        seq[$urandom_range(0, 3)] = 5'h1F;
      for (int k = 0; k < 4; k++) begin
        step(1, seq[k], rd, rclr());
        if ($urandom_range(0, 4) == 0)
          repeat ($urandom_range(1, 3)) step(0, 5'h00, rd, rclr());
      end
      if ($urandom_range(0, 1) == 0)
        repeat ($urandom_range(0, 4)) step(0, 5'h00, rd, rclr());
      else
        repeat ($urandom_range(14, 22)) step(0, 5'h00, rd, rclr());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_miss);
    $finish;
  end

endmodule
